// File: rtl/mod_mul_pipe_if.sv
// Operand/result bundle for the pipelined Barrett modular multiplier.
// Carries the quasi-static modulus and Barrett constant, the input and output
// valid/ready handshakes, the opaque tags, and the busy indication.
interface mod_mul_pipe_if #(
  parameter int W  = 16,
  parameter int TW = 8
);
  logic [W-1:0]  s;
  logic [W:0]    m;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  r;
  logic [TW-1:0] out_tag;
  logic          busy;

  // Operation source and result sink side.
  modport master (
    output s, m, in_valid, a, b, in_tag, out_ready,
    input  in_ready, out_valid, r, out_tag, busy
  );

  // Arithmetic core side.
  modport slave (
    input  s, m, in_valid, a, b, in_tag, out_ready,
    output in_ready, out_valid, r, out_tag, busy
  );
endinterface

// File: rtl/mod_mul_pipe.sv
// Barrett modular multiplier r = a*b mod s, one tagged operation per cycle.
// Latency: 4 cycles (S1 product, S2 quotient estimate, S3 remainder, S4 correction).
// Backpressure: all stages hold while a result waits; in_ready = !out_valid || out_ready.
module mod_mul_pipe #(
  parameter int FIELD_WIDTH = 16,
  parameter int TAG_WIDTH   = 8
) (
  input logic           clk,
  input logic           reset,
  mod_mul_pipe_if.slave bus
);
  localparam int W = FIELD_WIDTH;

  // Stage valid bits and tags.
  logic                 v1_q, v2_q, v3_q, v4_q;
  logic [TAG_WIDTH-1:0] tag1_q, tag2_q, tag3_q, tag4_q;

  // Stage data. S2 keeps only the low W+2 bits of ab, which is all the
  // modular remainder computation needs, and stores the shifted quotient.
  logic [2*W-1:0] ab1_q;
  logic [W+1:0]   ab2_q;
  logic [W:0]     q3_q;
  logic [W+1:0]   r0_q;
  logic [W-1:0]   r_q;

  // Next-state values.
  logic [2*W-1:0] ab_d;
  logic [W:0]     q1;
  logic [2*W+1:0] q2_d;
  logic [W+1:0]   q3s;
  logic [W+1:0]   r0_d;
  logic [W+1:0]   s_ext;
  logic [W+1:0]   r1;
  logic [W+1:0]   r2;
  logic [W-1:0]   r_d;
  logic           unused_bits;
  logic           adv;

  // The pipeline moves only when the output register is empty or being drained.
  assign adv = !v4_q || bus.out_ready;

  // Datapath: full product, quotient estimate, remainder mod 2^(W+2), two corrections.
  always_comb begin
    ab_d  = {{W{1'b0}}, bus.a} * {{W{1'b0}}, bus.b};
    q1    = ab1_q[2*W-1:W-1];
    q2_d  = {{(W+1){1'b0}}, q1} * {{(W+1){1'b0}}, bus.m};
    // Only the low W+2 bits of q3*s matter because the true remainder is < 2^(W+2).
    q3s   = {1'b0, q3_q} * {2'b00, bus.s};
    r0_d  = ab2_q - q3s;
    s_ext = {2'b00, bus.s};
    r1    = (r0_q >= s_ext) ? (r0_q - s_ext) : r0_q;
    r2    = (r1 >= s_ext) ? (r1 - s_ext) : r1;
    r_d   = r2[W-1:0];
    // Low quotient bits are shifted away and r2 is always below s.
    unused_bits = ^{q2_d[W:0], r2[W+1:W]};
  end

  // Pipeline registers: shift together on adv, hold everything otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      v4_q   <= 1'b0;
      tag1_q <= '0;
      tag2_q <= '0;
      tag3_q <= '0;
      tag4_q <= '0;
      ab1_q  <= '0;
      ab2_q  <= '0;
      q3_q   <= '0;
      r0_q   <= '0;
      r_q    <= '0;
    end else if (adv) begin
      v1_q   <= bus.in_valid;
      v2_q   <= v1_q;
      v3_q   <= v2_q;
      v4_q   <= v3_q;
      tag1_q <= bus.in_tag;
      tag2_q <= tag1_q;
      tag3_q <= tag2_q;
      tag4_q <= tag3_q;
      ab1_q  <= ab_d;
      ab2_q  <= ab1_q[W+1:0];
      q3_q   <= q2_d[2*W+1:W+1];
      r0_q   <= r0_d;
      r_q    <= r_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = v4_q;
  assign bus.r         = r_q;
  assign bus.out_tag   = tag4_q;
  assign bus.busy      = v1_q | v2_q | v3_q | v4_q;
endmodule

// File: doc/mod_mul_pipe.md
Name: mod_mul_pipe

Overview:
- Fully pipelined Barrett modular multiplier: r = a*b mod s, parametrised in field width.
- Accepts one operand pair per cycle, with valid/ready handshake on both sides, full backpressure and a passthrough tag.
- Performs exact final reduction (two conditional subtracts), so the result is always in [0, s).
- Drop-in arithmetic core for MSM point-arithmetic datapaths (EC add/double sequencers feed it tagged operations).

Parameters:
FIELD_WIDTH, 16, bit width W of field elements and modulus
TAG_WIDTH, 8, width of opaque tag carried alongside each operation

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all pipeline valid bits
s  input  FIELD_WIDTH  modulus; s[W-1] must be 1; quasi-static
m  input  FIELD_WIDTH+1  Barrett constant floor(2^(2W)/s); quasi-static
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operand pair this cycle
a  input  FIELD_WIDTH  first operand, must be < s
b  input  FIELD_WIDTH  second operand, must be < s
in_tag  input  TAG_WIDTH  tag for this operation
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
r  output  FIELD_WIDTH  a*b mod s
out_tag  output  TAG_WIDTH  tag of the operation that produced r
busy  output  1  any pipeline stage holds a valid operation

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream): all stage valid bits 0, so out_valid=0 and busy=0. Data registers may be left unreset, but r and out_tag read 0 after reset. Reset mid-operation discards all in-flight work; no result for those operations ever appears.
- Transfer rules: input handshake when in_valid && in_ready; output handshake when out_valid && out_ready.
- Pipeline enable: adv = !out_valid || out_ready. in_ready = adv (combinational from out_ready and stage-4 valid only, not from in_valid).
- When adv=0, all stages hold, including data, valid and tag. When adv=1, every stage shifts. A stage receiving a bubble gets valid=0.
- Latency: 4 cycles from accepting handshake to out_valid when no stall. Throughput 1 operation/cycle. Results are delivered in order.
- S1: ab = a*b, 2W bits, full precision.
- S2: q1 = ab >> (W-1), W+1 bits. q2 = q1*m, 2W+2 bits. ab is carried forward.
- S3: q3 = q2 >> (W+1), W+1 bits. r0 = (ab - q3*s) mod 2^(W+2). Exact because 0 <= true remainder < 3s < 2^(W+2).
- S4: r1 = r0 >= s ? r0-s : r0. r = r1 >= s ? r1-s : r1. Both compares are unsigned, W+2 bits. Output registered.
- Tag travels with its operation through all 4 stages unchanged.
- busy = OR of the four stage valid bits.
- s and m may change only while busy=0 and in_valid=0. Results are undefined if they change otherwise, or if a >= s, b >= s, or s[W-1]=0.
- out_valid stays high and r/out_tag stay stable until out_ready (AXI-style). in_valid may be asserted without waiting for in_ready; the source must hold a, b, in_tag while in_valid && !in_ready.
- Simultaneous output handshake and input acceptance in the same cycle is legal and keeps full throughput.

Test Plan:
- W=16, s=65521, m=65551, out_ready=1. Send (2,3,tag=1), then (65520,65520,tag=2), then (0,12345,tag=3) on back-to-back cycles. Required: r=6, 1, 0 with tags 1, 2, 3 on consecutive cycles, first result 4 cycles after acceptance.
- s=32769, m=131068. Send (32768,32768) -> r=1. Send (32768,2) -> r=32767. Both exercise the S4 double-subtract path.
- Backpressure: stream 8 ops with out_ready=1; drop out_ready for 3 cycles mid-stream. Required: in_ready=0 during the stall, r/out_tag held stable, no loss or duplication, all 8 results in order.
- Reset mid-stream: accept 3 ops, assert reset on cycle 2. Required: out_valid=0 and busy=0 immediately. After release, a fresh op (65520,2) with s=65521 returns 65519 and no stale results appear.
- Random: 10k random a,b < s for s in {65521, 40961, 32771} with random in_valid/out_ready. Scoreboard compares against a*b % s and tag order.
- Idle: in_valid=0 for 20 cycles. Required: out_valid=0 and busy=0 throughout, in_ready=1.
